imem_loader: RTL and testbench

Program loader that fills the instruction memory from a byte stream (fed by the UART receiver) before the core runs. Assembles little-endian bytes into 32-bit words and issues one write per word through the instruction memory's write port. Holds the CPU in reset until a complete program has been written. It is the write-side counterpart of the read-only, word-aligned instruction fetch path.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a little-endian byte stream
// (LEN_LO, LEN_HI, then N words of 4 bytes) and holds the CPU in reset
// until the whole program has been written.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start, no bytes accepted
// S_LEN_LO | accepting low byte of word count N
// S_LEN_HI | accepting high byte of N, validating it against DEPTH
// S_DATA   | assembling data bytes into words, one write per 4 bytes
// S_FIN    | final write strobe in flight, no bytes accepted
// S_CHK    | accepting checksum byte (checksum build only)
// S_DONE   | load complete, core released
// S_ERR    | load aborted, core held
module imem_loader #(
   parameter int DEPTH = 256,
   parameter int CNT_W = 9
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   output logic             byte_ready_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   output logic             cpu_hold_o,
   output logic             done_o,
   output logic             error_o,
   output logic [CNT_W-1:0] word_count_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_FIN    = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
      , S_CHK  = 3'd7
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [1:0]       idx_q, idx_d;
   logic [31:0]      asm_q, asm_d;
   logic [CNT_W-1:0] wc_q, wc_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   logic             xfer;
   logic [15:0]      hdr_len;
   logic [CNT_W-1:0] wc_inc;

   // Outputs decoded straight from the state register.
   always_comb begin
      byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_q == S_CHK) byte_ready_o = 1'b1;
`endif
      cpu_hold_o = (state_q != S_DONE);
      done_o     = (state_q == S_DONE);
      error_o    = (state_q == S_ERR);
   end

   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign word_count_o = wc_q;

   assign xfer    = byte_valid_i && byte_ready_o;
   assign hdr_len = {byte_data_i, len_q[7:0]};
   assign wc_inc  = wc_q + CNT_W'(1);

   // Next-state, byte assembly and write-strobe generation.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      wc_d    = wc_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_d = S_LEN_LO;
               wc_d    = '0;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = byte_data_i;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = byte_data_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = 8'h00;
`endif
               if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_DONE;
`endif
               end else if (hdr_len > 16'(DEPTH)) begin
                  state_d = S_ERR;
               end else begin
                  wc_d    = '0;
                  idx_d   = 2'd0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               // First byte ends up in [7:0] after four right-shifts.
               asm_d = {byte_data_i, asm_q[31:8]};
               idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_data_i;
`endif
               if (idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = 32'(wc_q) << 2;
                  wdata_d = asm_d;
                  wc_d    = wc_inc;
                  if (16'(wc_inc) == len_q) state_d = S_FIN;
               end
            end
         end
         // Lets the last strobe land before the core is released.
         S_FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         asm_q   <= '0;
         wc_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         wc_q    <= wc_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven check of the main load sequence plus
// hand-written sequences for length errors, byte gaps, mid-load reset,
// ignored start/byte pulses and (when compiled in) the checksum byte.
module tb_imem_loader;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_ready_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        cpu_hold_o;
   logic        done_o;
   logic        error_o;
   logic [8:0]  word_count_o;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;

   imem_loader #(.DEPTH(256), .CNT_W(9)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .cpu_hold_o   (cpu_hold_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .word_count_o (word_count_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (mem_we_o) we_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        start;
      logic        valid;
      logic [7:0]  data;
      logic        ready;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        done;
      logic        err;
      logic        hold;
      logic [8:0]  wc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic s, input logic v, input logic [7:0] d,
                               input logic rdy, input logic we, input logic [31:0] a,
                               input logic [31:0] w, input logic dn, input logic er,
                               input logic hd, input logic [8:0] wc);
      vec_t r;
      r.start = s; r.valid = v; r.data = d; r.ready = rdy; r.we = we;
      r.addr = a; r.wdata = w; r.done = dn; r.err = er; r.hold = hd; r.wc = wc;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic v, input logic [7:0] d);
      start_i = s; byte_valid_i = v; byte_data_i = d;
      @(posedge clk_i); #1;
      start_i = 1'b0; byte_valid_i = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b0, 1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00);
   endtask

   // After the last data byte: one cycle for the final strobe, then the checksum byte if built in.
   task automatic finish_load(input logic [7:0] cs);
      idle(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(cs);
`else
      if (cs === 8'hxx) $display("unreachable");
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ready"}, 32'(byte_ready_o), 32'd0);
      chk({tag, " we"},    32'(mem_we_o),     32'd0);
      chk({tag, " addr"},  mem_addr_o,        32'd0);
      chk({tag, " wdata"}, mem_wdata_o,       32'd0);
      chk({tag, " hold"},  32'(cpu_hold_o),   32'd1);
      chk({tag, " done"},  32'(done_o),       32'd0);
      chk({tag, " error"}, 32'(error_o),      32'd0);
      chk({tag, " wc"},    32'(word_count_o), 32'd0);
   endtask

   initial begin
      int base;

      // Main frame: N=2, words 0x00000013 and 0x00100093.
      add(1,0,8'h00, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h02, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h00, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h13, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h00, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h00, 1,0,32'h0,32'h0,         0,0,1,9'd0);
      add(0,1,8'h00, 1,1,32'h0,32'h00000013,  0,0,1,9'd1);
      add(0,1,8'h93, 1,0,32'h0,32'h00000013,  0,0,1,9'd1);
      add(0,1,8'h00, 1,0,32'h0,32'h00000013,  0,0,1,9'd1);
      add(0,1,8'h10, 1,0,32'h0,32'h00000013,  0,0,1,9'd1);
      add(0,1,8'h00, 0,1,32'h4,32'h00100093,  0,0,1,9'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
      add(0,0,8'h00, 1,0,32'h4,32'h00100093,  0,0,1,9'd2);
      add(0,1,8'h90, 0,0,32'h4,32'h00100093,  1,0,0,9'd2);
`else
      add(0,0,8'h00, 0,0,32'h4,32'h00100093,  1,0,0,9'd2);
`endif

      // Reset values while reset is held.
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk_reset_vals("reset");
      reset_i = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].start, tbl[i].valid, tbl[i].data);
         chk($sformatf("v%0d ready", i), 32'(byte_ready_o), 32'(tbl[i].ready));
         chk($sformatf("v%0d we", i),    32'(mem_we_o),     32'(tbl[i].we));
         chk($sformatf("v%0d addr", i),  mem_addr_o,        tbl[i].addr);
         chk($sformatf("v%0d wdata", i), mem_wdata_o,       tbl[i].wdata);
         chk($sformatf("v%0d done", i),  32'(done_o),       32'(tbl[i].done));
         chk($sformatf("v%0d error", i), 32'(error_o),      32'(tbl[i].err));
         chk($sformatf("v%0d hold", i),  32'(cpu_hold_o),   32'(tbl[i].hold));
         chk($sformatf("v%0d wc", i),    32'(word_count_o), 32'(tbl[i].wc));
      end
      chk("main we count", 32'(we_cnt), 32'd2);

      // N=257 exceeds DEPTH: error, no writes; then an empty program succeeds.
      base = we_cnt;
      step(1'b1, 1'b0, 8'h00);
      send(8'h01);
      send(8'h01);
      chk("len err error", 32'(error_o),    32'd1);
      chk("len err hold",  32'(cpu_hold_o), 32'd1);
      chk("len err ready", 32'(byte_ready_o), 32'd0);
      chk("len err done",  32'(done_o),     32'd0);
      idle(2);
      chk("len err we count", 32'(we_cnt - base), 32'd0);
      step(1'b1, 1'b0, 8'h00);
      chk("restart error cleared", 32'(error_o), 32'd0);
      send(8'h00);
      send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      chk("n0 done",  32'(done_o),     32'd1);
      chk("n0 hold",  32'(cpu_hold_o), 32'd0);
      chk("n0 error", 32'(error_o),    32'd0);

      // N=1 with 3 idle cycles between bytes.
      base = we_cnt;
      step(1'b1, 1'b0, 8'h00);
      chk("gap restart done cleared", 32'(done_o), 32'd0);
      chk("gap restart hold", 32'(cpu_hold_o), 32'd1);
      send(8'h01); idle(3);
      send(8'h00);
      for (int b = 0; b < 3; b++) begin
         idle(1); chk($sformatf("gap ready b%0d", b), 32'(byte_ready_o), 32'd1);
         idle(2); chk($sformatf("gap ready2 b%0d", b), 32'(byte_ready_o), 32'd1);
         send(8'hAA + 8'(b * 17));
      end
      idle(3);
      chk("gap ready last", 32'(byte_ready_o), 32'd1);
      chk("gap no early we", 32'(we_cnt - base), 32'd0);
      send(8'hDD);
      chk("gap we",    32'(mem_we_o), 32'd1);
      chk("gap addr",  mem_addr_o,    32'h0);
      chk("gap wdata", mem_wdata_o,   32'hDDCCBBAA);
      finish_load(8'h00);
      chk("gap done", 32'(done_o), 32'd1);
      chk("gap we count", 32'(we_cnt - base), 32'd1);

      // Reset after 2 of 4 data bytes, then a clean reload.
      step(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h00); send(8'h11); send(8'h22);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      chk_reset_vals("midreset");
      base = we_cnt;
      send(8'h33); send(8'h44);
      idle(3);
      chk("midreset no we", 32'(we_cnt - base), 32'd0);
      step(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("reload addr",  mem_addr_o,  32'h0);
      chk("reload wdata", mem_wdata_o, 32'h04030201);
      finish_load(8'h04);
      chk("reload done", 32'(done_o), 32'd1);
      chk("reload we count", 32'(we_cnt - base), 32'd1);

      // Bytes while IDLE are not consumed; start during DATA is ignored.
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      base = we_cnt;
      send(8'h05);
      chk("idle ready", 32'(byte_ready_o), 32'd0);
      send(8'h06);
      step(1'b1, 1'b0, 8'h00);
      send(8'h02); send(8'h00);
      send(8'h11); send(8'h22);
      step(1'b1, 1'b0, 8'h00);
      chk("start in data ready", 32'(byte_ready_o), 32'd1);
      chk("start in data wc",    32'(word_count_o), 32'd0);
      send(8'h33); send(8'h44);
      chk("sid w0 wdata", mem_wdata_o, 32'h44332211);
      chk("sid w0 wc",    32'(word_count_o), 32'd1);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      chk("sid w1 addr",  mem_addr_o,  32'h4);
      chk("sid w1 wdata", mem_wdata_o, 32'h88776655);
      chk("sid w1 wc",    32'(word_count_o), 32'd2);
      finish_load(8'h88);
      chk("sid done", 32'(done_o), 32'd1);
      chk("sid we count", 32'(we_cnt - base), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch.
      step(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      finish_load(8'h44);
      chk("csum ok done",  32'(done_o),  32'd1);
      chk("csum ok error", 32'(error_o), 32'd0);
      base = we_cnt;
      step(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      finish_load(8'h45);
      chk("csum bad error", 32'(error_o),    32'd1);
      chk("csum bad hold",  32'(cpu_hold_o), 32'd1);
      chk("csum bad done",  32'(done_o),     32'd0);
      chk("csum bad we count", 32'(we_cnt - base), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
